// File: rtl/core_trace_buffer.sv
// rtl/core_trace_buffer.sv - retire trace FIFO with filter, counters and hang detect
// Optional per-entry cycle stamp when TRACE_TIMESTAMP_EN is defined.
module core_trace_buffer #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int HANG_LIMIT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire_valid,
    input  logic [XLEN-1:0]            PC_in,
    input  logic [31:0]                Instr_in,
    input  logic [4:0]                 rd_in,
    input  logic [XLEN-1:0]            Data_in,
    input  logic                       RegWrite_in,
    input  logic                       MemWrite_in,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_data,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_stamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       hang,
    output logic [31:0]                cycle_cnt,
    output logic [31:0]                retire_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HANG_LIMIT + 1);

    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [XLEN-1:0] r_mem_data  [DEPTH];
    logic [4:0]      r_mem_rd    [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]     r_mem_stamp [DEPTH];
`endif

    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_cycle_cnt;
    logic [31:0]     r_retire_cnt;
    logic [HW-1:0]   r_noprog_cnt;
    logic [XLEN-1:0] r_last_pc;
    logic            r_overflow;
    logic            r_hang;

    logic            w_filter;
    logic            w_capture;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_noprog;

    always_comb begin
        w_filter = 1'b0;
        case (mode)
            2'b00:   w_filter = 1'b1;
            2'b01:   w_filter = RegWrite_in;
            2'b10:   w_filter = MemWrite_in;
            default: w_filter = 1'b0;
        endcase
    end

    assign w_capture = retire_valid & w_filter;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = (r_count != '0) & out_ready;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_noprog  = ~retire_valid | (PC_in == r_last_pc);

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem_pc[r_wptr]    <= PC_in;
            r_mem_instr[r_wptr] <= Instr_in;
            r_mem_data[r_wptr]  <= Data_in;
            r_mem_rd[r_wptr]    <= rd_in;
`ifdef TRACE_TIMESTAMP_EN
            r_mem_stamp[r_wptr] <= r_cycle_cnt;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_noprog_cnt <= '0;
            r_last_pc    <= '0;
            r_overflow   <= 1'b0;
            r_hang       <= 1'b0;
        end else if (clear) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_noprog_cnt <= '0;
            r_last_pc    <= '0;
            r_overflow   <= 1'b0;
            r_hang       <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (retire_valid) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
                r_last_pc    <= PC_in;
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_noprog) begin
                if (r_noprog_cnt != HW'(HANG_LIMIT)) r_noprog_cnt <= r_noprog_cnt + HW'(1);
                if (r_noprog_cnt >= HW'(HANG_LIMIT - 1)) r_hang <= 1'b1;
            end else begin
                r_noprog_cnt <= '0;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_pc     = r_mem_pc[r_rptr];
    assign out_instr  = r_mem_instr[r_rptr];
    assign out_data   = r_mem_data[r_rptr];
    assign out_rd     = r_mem_rd[r_rptr];
`ifdef TRACE_TIMESTAMP_EN
    assign out_stamp  = r_mem_stamp[r_rptr];
`else
    assign out_stamp  = 32'd0;
`endif
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign hang       = r_hang;
    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
endmodule

// File: doc/core_trace_buffer.md
CORE_TRACE_BUFFER -- requirements
Module: core_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width.
REQ-002 Parameter DEPTH, default 16, trace entries; power of two, 4..256.
REQ-003 Parameter HANG_LIMIT, default 64, consecutive no-progress cycles before hang flag.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 retire_valid  input  1  one instruction retires this cycle.
REQ-007 PC_in  input  XLEN  PC of retiring instruction.
REQ-008 Instr_in  input  32  retiring instruction word.
REQ-009 rd_in  input  5  destination register.
REQ-010 Data_in  input  XLEN  writeback value or store data.
REQ-011 RegWrite_in, MemWrite_in  input  1 each  retire-side write enables.
REQ-012 mode  input  2  capture filter: 00 all, 01 RegWrite only, 10 MemWrite only, 11 capture off.
REQ-013 clear  input  1  synchronous clear of FIFO, counters, sticky flags.
REQ-014 out_valid / out_ready  output / input  1 each  read-side handshake.
REQ-015 out_pc, out_instr, out_data  output  XLEN, 32, XLEN  head entry fields; out_rd output 5.
REQ-016 out_stamp  output  32  head entry cycle stamp.
REQ-017 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 overflow, hang  output  1 each  sticky status flags.
REQ-019 cycle_cnt, retire_cnt  output  32 each  free-running counters.

Function
REQ-020 Capture = retire_valid AND filter(mode, RegWrite_in, MemWrite_in) true; captured entry written at rising edge, visible on out_* next cycle (1-cycle latency).
REQ-021 Storage is a circular FIFO, write/read pointers wrap modulo DEPTH.
REQ-022 Pop occurs when out_valid AND out_ready at rising edge; out_* shows new head next cycle.
REQ-023 out_valid = (count != 0); out_* hold stable while out_valid high and out_ready low.
REQ-024 Full and capture without pop: entry dropped (drop-newest), overflow set, FIFO contents unchanged.
REQ-025 Full and capture with pop: both occur, count stays DEPTH, no overflow.
REQ-026 Empty and capture: entry stored; no same-cycle bypass to out_*.
REQ-027 cycle_cnt increments every cycle, wraps 0xFFFFFFFF -> 0.
REQ-028 retire_cnt increments on every retire_valid regardless of mode, wraps.
REQ-029 No-progress counter: increments each cycle without retire_valid or with retire_valid and PC_in equal to last retired PC; resets to 0 otherwise.
REQ-030 hang set when no-progress counter reaches HANG_LIMIT; counter saturates there.
REQ-031 clear has priority over capture and pop in the same cycle: pointers, count, counters, flags to 0, last PC to 0.
REQ-032 Mode change takes effect on the same cycle's capture decision; existing entries unaffected.

Reset
REQ-033 On reset low, asynchronously: pointers, count, cycle_cnt, retire_cnt, no-progress counter, last PC, overflow, hang to 0; out_valid 0.
REQ-034 Storage array not reset; out_pc/out_instr/out_data/out_rd/out_stamp undefined-content but ignored while out_valid 0.
REQ-035 Reset asserted mid-operation discards all entries; first capture after release stored at pointer 0.

Configuration
REQ-036 Macro TRACE_TIMESTAMP_EN defined: each entry stores cycle_cnt at capture; out_stamp presents it.
REQ-037 Macro TRACE_TIMESTAMP_EN undefined: no stamp storage; out_stamp driven constant 0; all other behaviour identical.

Verification
REQ-038 Reset release, mode 00, 3 retires PC 0x0,0x4,0x8, out_ready 0 -> count 3, out_pc 0x00000000, out_valid 1.
REQ-039 DEPTH 16, 17 captures no pop -> count 16, overflow 1, drained entries are first 16 PCs in order.
REQ-040 Full FIFO, capture and pop same cycle -> count 16, overflow 0, newest entry at tail.
REQ-041 mode 01, retires alternate RegWrite 1/0 over 8 cycles -> count 4, retire_cnt 8.
REQ-042 retire_valid held 0 for 64 cycles after reset -> hang 1 at cycle 64; clear pulse -> hang 0, cycle_cnt 0.
REQ-043 TRACE_TIMESTAMP_EN defined, capture at cycle_cnt 5 -> out_stamp 0x00000005; undefined -> out_stamp 0.
